// File: rtl/perf_hist_monitor.sv
// Purpose: hardware performance monitor with event counters, per-channel occupancy histograms and a retire watchdog.
// Latency: counters update one cycle after sampling; each dump word takes a LOAD and a SEND cycle (2 cycles minimum).
// Backpressure: the dump word is held stable while out_valid & ~out_ready; counting continues during a stall.
module perf_hist_monitor #(
  parameter int NCHAN      = 3,
  parameter int OCC_W      = 8,
  parameter int NBINS      = 17,
  parameter int CNT_W      = 32,
  parameter int RET_W      = 2,
  parameter int WDOG_W     = 16,
  parameter int WDOG_LIMIT = 5000,
  parameter int IDX_W      = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [RET_W-1:0]       ret_cnt,
  input  logic [RET_W-1:0]       br_cnt,
  input  logic [RET_W-1:0]       mp_cnt,
  input  logic [NCHAN*OCC_W-1:0] occ,
  input  logic [NCHAN-1:0]       occ_valid,
  input  logic                   clr,
  input  logic                   dump_start,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_index,
  output logic [CNT_W-1:0]       out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   wdog_trip
);

  localparam int                NWORDS   = 4 + NCHAN * NBINS;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;
  localparam logic [WDOG_W-1:0] WLIM     = WDOG_W'(WDOG_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  // Saturating add of a small per-cycle count onto a counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [RET_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W + 1 - RET_W){1'b0}}, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0]  cyc_q, cyc_d, inst_q, inst_d, br_q, br_d, mp_q, mp_d;
  logic [CNT_W-1:0]  hist_q [NCHAN][NBINS];
  logic [CNT_W-1:0]  hist_d [NCHAN][NBINS];
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              trip_q, trip_d;
  logic [CNT_W-1:0]  word;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              out_valid_q, out_last_q, busy_q;
  logic [IDX_W-1:0]  out_index_q;
  logic [CNT_W-1:0]  out_data_q;

  // Next-state for counters, histograms and watchdog; clr discards same-cycle events.
  always_comb begin
    cyc_d  = cyc_q;
    inst_d = inst_q;
    br_d   = br_q;
    mp_d   = mp_q;
    wdog_d = wdog_q;
    trip_d = trip_q;
    for (int c = 0; c < NCHAN; c++) begin
      for (int b = 0; b < NBINS; b++) begin
        hist_d[c][b] = hist_q[c][b];
      end
    end
    if (clr) begin
      cyc_d  = '0;
      inst_d = '0;
      br_d   = '0;
      mp_d   = '0;
      wdog_d = '0;
      trip_d = 1'b0;
      for (int c = 0; c < NCHAN; c++) begin
        for (int b = 0; b < NBINS; b++) begin
          hist_d[c][b] = '0;
        end
      end
    end else if (en) begin
      cyc_d  = sat_add(cyc_q, RET_W'(1));
      inst_d = sat_add(inst_q, ret_cnt);
      br_d   = sat_add(br_q, br_cnt);
      mp_d   = sat_add(mp_q, mp_cnt);
      // The top bin collects every occupancy at or above NBINS-1.
      for (int c = 0; c < NCHAN; c++) begin
        for (int b = 0; b < NBINS; b++) begin
          if (occ_valid[c] &&
              ((b == NBINS - 1) ? (int'(occ[c*OCC_W +: OCC_W]) >= NBINS - 1)
                                : (int'(occ[c*OCC_W +: OCC_W]) == b)) &&
              (hist_q[c][b] != CNT_MAX)) begin
            hist_d[c][b] = hist_q[c][b] + CNT_W'(1);
          end
        end
      end
      if (ret_cnt != '0) begin
        wdog_d = '0;
      end else if (wdog_q != WDOG_MAX) begin
        wdog_d = wdog_q + WDOG_W'(1);
      end
      // Sticky: once the idle count reaches the limit only clr or reset removes the flag.
      if (wdog_d == WLIM) begin
        trip_d = 1'b1;
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q  <= '0;
      inst_q <= '0;
      br_q   <= '0;
      mp_q   <= '0;
      wdog_q <= '0;
      trip_q <= 1'b0;
      for (int c = 0; c < NCHAN; c++) begin
        for (int b = 0; b < NBINS; b++) begin
          hist_q[c][b] <= '0;
        end
      end
    end else begin
      cyc_q  <= cyc_d;
      inst_q <= inst_d;
      br_q   <= br_d;
      mp_q   <= mp_d;
      wdog_q <= wdog_d;
      trip_q <= trip_d;
      for (int c = 0; c < NCHAN; c++) begin
        for (int b = 0; b < NBINS; b++) begin
          hist_q[c][b] <= hist_d[c][b];
        end
      end
    end
  end

  // Dump word select: four event counters followed by histograms, channel-major.
  always_comb begin
    word = '0;
    if (idx_q == IDX_W'(0)) word = cyc_q;
    if (idx_q == IDX_W'(1)) word = inst_q;
    if (idx_q == IDX_W'(2)) word = br_q;
    if (idx_q == IDX_W'(3)) word = mp_q;
    for (int c = 0; c < NCHAN; c++) begin
      for (int b = 0; b < NBINS; b++) begin
        if (idx_q == IDX_W'(4 + c * NBINS + b)) word = hist_q[c][b];
      end
    end
  end

  // Dump FSM with registered outputs; clr aborts any dump in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clr) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dump_start) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          out_data_q  <= word;
          out_index_q <= idx_q;
          out_last_q  <= (idx_q == LAST_IDX);
          out_valid_q <= 1'b1;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= S_LOAD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign wdog_trip = trip_q;

endmodule

// File: tb/tb_perf_hist_monitor.sv
// Bench for perf_hist_monitor: two instances (32-bit and 8-bit counters) share stimulus.
// A reference model kept as plain integers produces expected dump words into queues.
// A negedge monitor pops and compares each accepted word and checks the watchdog flag every cycle.
module tb_perf_hist_monitor;
  localparam int NCHAN = 3;
  localparam int NBINS = 17;
  localparam int NW    = 4 + NCHAN * NBINS;
  localparam int WLIM  = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, clr = 1'b0, dump_start = 1'b0, out_ready = 1'b1;
  logic [1:0]  ret_cnt = '0, br_cnt = '0, mp_cnt = '0;
  logic [23:0] occ = '0;
  logic [2:0]  occ_valid = '0;

  logic        out_valid_a, out_last_a, busy_a, wdog_trip_a;
  logic [5:0]  out_index_a;
  logic [31:0] out_data_a;
  logic        out_valid_b, out_last_b, busy_b, wdog_trip_b;
  logic [5:0]  out_index_b;
  logic [7:0]  out_data_b;

  perf_hist_monitor u_a (
    .clk(clk), .rst(rst), .en(en), .ret_cnt(ret_cnt), .br_cnt(br_cnt), .mp_cnt(mp_cnt),
    .occ(occ), .occ_valid(occ_valid), .clr(clr), .dump_start(dump_start),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_index(out_index_a),
    .out_data(out_data_a), .out_last(out_last_a), .busy(busy_a), .wdog_trip(wdog_trip_a)
  );

  perf_hist_monitor #(.CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .en(en), .ret_cnt(ret_cnt), .br_cnt(br_cnt), .mp_cnt(mp_cnt),
    .occ(occ), .occ_valid(occ_valid), .clr(clr), .dump_start(dump_start),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_index(out_index_b),
    .out_data(out_data_b), .out_last(out_last_b), .busy(busy_b), .wdog_trip(wdog_trip_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: unbounded counts, saturation applied when reading out.
  longint m_cyc, m_ret, m_br, m_mp;
  longint m_hist [NCHAN][NBINS];
  int     m_wdog;
  bit     m_trip;

  typedef struct { int idx; longint data; bit last; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] cap_a [NW];
  logic [7:0]  cap_b [NW];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (64'sd1 <<< w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    m_cyc = 0; m_ret = 0; m_br = 0; m_mp = 0; m_wdog = 0; m_trip = 0;
    for (int c = 0; c < NCHAN; c++)
      for (int b = 0; b < NBINS; b++) m_hist[c][b] = 0;
  endtask

  task automatic model_step();
    int o;
    if (clr) begin
      model_clear();
    end else if (en) begin
      m_cyc += 1;
      m_ret += ret_cnt;
      m_br  += br_cnt;
      m_mp  += mp_cnt;
      for (int c = 0; c < NCHAN; c++) begin
        if (occ_valid[c]) begin
          o = int'(occ[c*8 +: 8]);
          m_hist[c][(o > NBINS - 1) ? NBINS - 1 : o] += 1;
        end
      end
      if (ret_cnt != 0) m_wdog = 0;
      else if (m_wdog < 65535) m_wdog += 1;
      if (m_wdog == WLIM) m_trip = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  function automatic longint mword(input int i);
    if (i == 0) return m_cyc;
    if (i == 1) return m_ret;
    if (i == 2) return m_br;
    if (i == 3) return m_mp;
    return m_hist[(i - 4) / NBINS][(i - 4) % NBINS];
  endfunction

  // Expected words; in a live dump only the cycle counter moves, and word 0 sees one extra cycle.
  task automatic push_dump(input bit live);
    exp_t e;
    longint v;
    for (int i = 0; i < NW; i++) begin
      v = mword(i);
      if (live && i == 0) v += 1;
      e.idx = i; e.last = (i == NW - 1);
      e.data = sat(v, 32); qa.push_back(e);
      e.data = sat(v, 8);  qb.push_back(e);
      cap_a[i] = 32'hDEAD_BEEF;
      cap_b[i] = 8'hA5;
    end
  endtask

  // Monitor: pops the scoreboard on each accepted word, checks watchdog flag every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("wdog_trip_a", wdog_trip_a, m_trip);
      check("wdog_trip_b", wdog_trip_b, m_trip);
      if (out_valid_a && out_ready) begin
        if (qa.size() == 0) check("extra_word_a", out_index_a, 99);
        else begin
          e = qa.pop_front();
          check("index_a", out_index_a, e.idx);
          check("data_a", out_data_a, e.data);
          check("last_a", out_last_a, e.last);
          cap_a[out_index_a] = out_data_a;
        end
      end
      if (out_valid_b && out_ready) begin
        if (qb.size() == 0) check("extra_word_b", out_index_b, 99);
        else begin
          e = qb.pop_front();
          check("index_b", out_index_b, e.idx);
          check("data_b", out_data_b, e.data);
          check("last_b", out_last_b, e.last);
          cap_b[out_index_b] = out_data_b;
        end
      end
    end
  end

  task automatic run_dump(input bit live, input int stall_idx, input int restart_idx, input int abort_idx);
    int  n;
    bit  aborted;
    int  s_idx;
    int  r_idx;
    s_idx = stall_idx; r_idx = restart_idx; aborted = 0; n = 0;
    en = live; ret_cnt = 0; br_cnt = 0; mp_cnt = 0; occ_valid = 0; clr = 0; out_ready = 1;
    check("busy_before", busy_a, 0);
    push_dump(live);
    dump_start = 1;
    tick();
    dump_start = 0;
    check("busy_after_start", busy_a, 1);
    while (busy_a && n < 1000 && !aborted) begin
      if (out_valid_a && int'(out_index_a) == s_idx && qa.size() > 0) begin
        out_ready = 0;
        for (int k = 0; k < 7; k++) begin
          tick();
          check("stall_valid", out_valid_a, 1);
          check("stall_index", out_index_a, s_idx);
          check("stall_data", out_data_a, qa[0].data);
        end
        out_ready = 1;
        s_idx = -1;
      end
      if (out_valid_a && int'(out_index_a) == r_idx) begin
        dump_start = 1;
        r_idx = -1;
      end
      if (out_valid_a && int'(out_index_a) == abort_idx) begin
        clr = 1; out_ready = 0;
        tick();
        clr = 0; out_ready = 1;
        check("abort_valid", out_valid_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_busy_b", busy_b, 0);
        qa.delete(); qb.delete();
        aborted = 1;
      end else begin
        tick();
        dump_start = 0;
        n++;
      end
    end
    if (n >= 1000) check("dump_timeout", n, 0);
    if (!aborted) begin
      check("words_left_a", qa.size(), 0);
      check("words_left_b", qb.size(), 0);
    end
    en = 0;
  endtask

  initial begin
    int n;
    model_clear();
    #12;
    check("rst_valid", out_valid_a, 0);
    check("rst_index", out_index_a, 0);
    check("rst_data", out_data_a, 0);
    check("rst_last", out_last_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_wdog", wdog_trip_a, 0);
    @(posedge clk); #1;
    rst = 1;

    // Directed: ten retiring cycles, three branches, one mispredict, channel 0 occupancy.
    for (int i = 0; i < 10; i++) begin
      en = 1; ret_cnt = 1; br_cnt = (i < 3); mp_cnt = (i == 0);
      occ = '0;
      occ[7:0] = (i < 4) ? 8'd5 : 8'd200;
      occ_valid = (i < 6) ? 3'b001 : 3'b000;
      tick();
    end
    run_dump(0, 2, 6, -1);
    check("dir_cycles", cap_a[0], 10);
    check("dir_instret", cap_a[1], 10);
    check("dir_branches", cap_a[2], 3);
    check("dir_mispreds", cap_a[3], 1);
    check("dir_hist0_5", cap_a[9], 4);
    check("dir_hist0_16", cap_a[20], 2);
    for (int i = 21; i < NW; i++) check("dir_hist12_zero", cap_a[i], 0);

    // Counting continues during a dump.
    run_dump(1, -1, -1, -1);

    // Randomized traffic, then a static dump against the model.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      ret_cnt = 2'($urandom); br_cnt = 2'($urandom); mp_cnt = 2'($urandom);
      for (int c = 0; c < NCHAN; c++)
        occ[c*8 +: 8] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 18));
      occ_valid = 3'($urandom);
      clr = ($urandom_range(0, 149) == 0);
      tick();
    end
    clr = 0;
    run_dump(0, -1, -1, -1);

    // clr wins over same-cycle events.
    en = 1; ret_cnt = 1; br_cnt = 1; clr = 1;
    tick();
    clr = 0;
    run_dump(0, -1, -1, -1);
    check("clr_cycles", cap_a[0], 0);
    check("clr_instret", cap_a[1], 0);

    // Saturation of the 8-bit instance, then abort a dump at index 10.
    for (int i = 0; i < 300; i++) begin
      en = 1; ret_cnt = 1; br_cnt = 1; mp_cnt = 0; occ_valid = 0;
      tick();
    end
    run_dump(0, -1, -1, 10);
    check("sat_cycles_b", cap_b[0], 255);
    check("sat_instret_b", cap_b[1], 255);
    check("sat_cycles_a", cap_a[0], 300);
    check("sat_instret_a", cap_a[1], 300);

    // Watchdog trips on the 5000th idle cycle and is sticky until clr.
    en = 1; ret_cnt = 0; br_cnt = 0;
    for (int i = 0; i < WLIM - 1; i++) tick();
    check("wdog_4999", wdog_trip_a, 0);
    tick();
    check("wdog_5000", wdog_trip_a, 1);
    ret_cnt = 1;
    tick();
    check("wdog_sticky", wdog_trip_a, 1);
    clr = 1;
    tick();
    clr = 0;
    check("wdog_clr", wdog_trip_a, 0);

    // Asynchronous reset in the middle of a dump.
    en = 0; ret_cnt = 0;
    push_dump(0);
    dump_start = 1;
    tick();
    dump_start = 0;
    n = 0;
    while (!(out_valid_a && out_index_a == 6'd5) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("arst_timeout", n, 0);
    @(negedge clk);
    #2;
    rst = 0;
    #1;
    check("arst_valid", out_valid_a, 0);
    check("arst_index", out_index_a, 0);
    check("arst_data", out_data_a, 0);
    check("arst_last", out_last_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_valid_b", out_valid_b, 0);
    model_clear();
    qa.delete(); qb.delete();
    @(posedge clk); #1;
    rst = 1;
    run_dump(0, -1, -1, -1);
    check("post_rst_cycles", cap_a[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
